reg_bus_arbiter: RTL and testbench

REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

---
 rtl/reg_bus_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_reg_bus_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_arbiter.sv
// -----------------------------------------------------------------------------
// reg_bus_arbiter
//
// Two-master arbiter for a shared register bus. Masters m0 and m1 request
// accesses. A round-robin pointer picks the winner when both request at once.
// The winner's address, write data and direction are latched at grant. The
// bus stays in ACCESS until the slave acks or until TIMEOUT cycles pass. A
// single RESP cycle then returns done/err/rdata to the winner.
//
// Parameters
//   TIMEOUT  ACCESS cycles without bus_ack before the transfer aborts with err
//   ADDR_W   register address width
//   DATA_W   register data width
//
// Ports
//   clk                    rising-edge clock
//   rst                    asynchronous reset, active low
//   m0_req / m1_req        access request, held until that master's done
//   m0_addr / m1_addr      register address, sampled at grant
//   m0_wdata / m1_wdata    write data, sampled at grant
//   m0_wr / m1_wr          1 = write, 0 = read, sampled at grant
//   m0_gnt / m1_gnt        master owns the bus (ACCESS and RESP)
//   m0_done / m1_done      one-cycle completion pulse
//   m0_err / m1_err        timeout abort flag, valid with done
//   m_rdata                read data of the completed transfer
//   bus_addr               shared bus address
//   bus_wdata              shared bus write data
//   bus_wr                 write qualifier, only high during ACCESS
//   bus_en                 access strobe, high for the whole ACCESS state
//   bus_rdata              slave read data, captured with bus_ack
//   bus_ack                slave completion, only used during ACCESS
// -----------------------------------------------------------------------------
module reg_bus_arbiter #(
    parameter int TIMEOUT = 15,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_wr,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_wr,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic              m1_err,

    output logic [DATA_W-1:0] m_rdata,

    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_wr,
    output logic              bus_en,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack
);

    localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic                ptr_q;      // preferred master: 0 = m0, 1 = m1
    logic                owner_q;    // master that holds the bus
    logic [CNT_W-1:0]    cnt_q;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

    logic                any_req;
    logic                win;
    logic                cnt_expired;

    assign any_req     = m0_req | m1_req;
    // A lone requester wins outright; the pointer only breaks ties.
    assign win         = (m0_req && m1_req) ? ptr_q : m1_req;
    assign cnt_expired = (cnt_q == CNT_LAST);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // An ack on the last allowed cycle still ends the access
                // normally; the datapath gives it priority over the abort.
                if (bus_ack || cnt_expired) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM outputs
    // -------------------------------------------------------------------------
    always_comb begin
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        m0_done   = 1'b0;
        m1_done   = 1'b0;
        m0_err    = 1'b0;
        m1_err    = 1'b0;
        bus_en    = 1'b0;
        bus_wr    = 1'b0;
        m_rdata   = rdata_q;
        bus_addr  = addr_q;
        bus_wdata = wdata_q;
        case (state_q)
            ACCESS: begin
                m0_gnt = ~owner_q;
                m1_gnt =  owner_q;
                bus_en = 1'b1;
                bus_wr = wr_q;
            end
            RESP: begin
                m0_gnt  = ~owner_q;
                m1_gnt  =  owner_q;
                m0_done = ~owner_q;
                m1_done =  owner_q;
                m0_err  = ~owner_q & err_q;
                m1_err  =  owner_q & err_q;
            end
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Grant latch, timeout counter, response capture and round-robin pointer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q <= win;
                        wr_q    <= win ? m1_wr    : m0_wr;
                        addr_q  <= win ? m1_addr  : m0_addr;
                        wdata_q <= win ? m1_wdata : m0_wdata;
                        cnt_q   <= '0;
                    end
                end
                ACCESS: begin
                    if (bus_ack) begin
                        rdata_q <= wr_q ? '0 : bus_rdata;
                        err_q   <= 1'b0;
                    end else if (cnt_expired) begin
                        rdata_q <= '1;
                        err_q   <= 1'b1;
                    end else begin
                        // Stops at CNT_LAST, so the counter never wraps.
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    ptr_q <= ~owner_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_bus_arbiter
//
// Directed bench for reg_bus_arbiter. Cycle vectors hold the inputs applied
// before a rising edge and the outputs expected just after it. Hand-written
// sequences cover the timeout abort, the ack on the last allowed cycle, and
// a reset in the middle of a transfer.
// -----------------------------------------------------------------------------
module tb_reg_bus_arbiter;

    logic       clk;
    logic       rst;
    logic       m0_req, m1_req;
    logic [6:0] m0_addr, m1_addr;
    logic [7:0] m0_wdata, m1_wdata;
    logic       m0_wr, m1_wr;
    logic       m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err;
    logic [7:0] m_rdata;
    logic [6:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_wr, bus_en;
    logic [7:0] bus_rdata;
    logic       bus_ack;

    int n_chk  = 0;
    int n_fail = 0;

    reg_bus_arbiter #(.TIMEOUT(15)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (m0_req),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_wr    (m0_wr),
        .m0_gnt   (m0_gnt),
        .m0_done  (m0_done),
        .m0_err   (m0_err),
        .m1_req   (m1_req),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_wr    (m1_wr),
        .m1_gnt   (m1_gnt),
        .m1_done  (m1_done),
        .m1_err   (m1_err),
        .m_rdata  (m_rdata),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_wr   (bus_wr),
        .bus_en   (bus_en),
        .bus_rdata(bus_rdata),
        .bus_ack  (bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control bits: {m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, bus_en, bus_wr}
    localparam logic [7:0] C_IDLE     = 8'b0000_0000;
    localparam logic [7:0] C_M0_ACC_W = 8'b1000_0011;
    localparam logic [7:0] C_M0_ACC_R = 8'b1000_0010;
    localparam logic [7:0] C_M0_OK    = 8'b1010_0000;
    localparam logic [7:0] C_M0_TMO   = 8'b1010_1000;
    localparam logic [7:0] C_M1_ACC_W = 8'b0100_0011;
    localparam logic [7:0] C_M1_ACC_R = 8'b0100_0010;
    localparam logic [7:0] C_M1_OK    = 8'b0101_0000;

    typedef struct {
        logic       nrst;
        logic       r0, w0;
        logic [6:0] a0;
        logic [7:0] d0;
        logic       r1, w1;
        logic [6:0] a1;
        logic [7:0] d1;
        logic       ack;
        logic [7:0] rd;
        logic [7:0] exp_ctl;
        logic [6:0] exp_addr;
        logic [7:0] exp_wd;
        logic       chk_rd;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic nrst,
        input logic r0, input logic w0, input logic [6:0] a0, input logic [7:0] d0,
        input logic r1, input logic w1, input logic [6:0] a1, input logic [7:0] d1,
        input logic ack, input logic [7:0] rd,
        input logic [7:0] exp_ctl, input logic [6:0] exp_addr, input logic [7:0] exp_wd,
        input logic chk_rd, input logic [7:0] exp_rd);
        vec_t v;
        v.nrst = nrst;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.ack = ack; v.rd = rd;
        v.exp_ctl = exp_ctl; v.exp_addr = exp_addr; v.exp_wd = exp_wd;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd;
        return v;
    endfunction

    function automatic logic [7:0] ctl();
        return {m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, bus_en, bus_wr};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_cnt;
        int en_hi;
        logic got_done;

        rst = 1'b0;
        m0_req = 0; m0_addr = '0; m0_wdata = '0; m0_wr = 0;
        m1_req = 0; m1_addr = '0; m1_wdata = '0; m1_wr = 0;
        bus_rdata = '0; bus_ack = 0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctl",   {24'd0, ctl()},     {24'd0, C_IDLE});
        chk("reset_addr",  {25'd0, bus_addr},  32'h0);
        chk("reset_wdata", {24'd0, bus_wdata}, 32'h0);
        chk("reset_rdata", {24'd0, m_rdata},   32'h0);

        // ---- vector table ----
        // m0 writes 12/A5, ack in first ACCESS cycle (slave data must be ignored)
        vecs.push_back(mk(1, 1,1,7'h12,8'hA5, 0,0,7'h00,8'h00, 0,8'h00, C_M0_ACC_W, 7'h12, 8'hA5, 0, 8'h00));
        vecs.push_back(mk(1, 1,1,7'h12,8'hA5, 0,0,7'h00,8'h00, 1,8'h66, C_M0_OK,    7'h00, 8'h00, 1, 8'h00));
        vecs.push_back(mk(1, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 0,8'h00, C_IDLE,     7'h00, 8'h00, 0, 8'h00));
        // m1 reads 05, ack in 4th ACCESS cycle; later input changes ignored
        vecs.push_back(mk(1, 0,0,7'h00,8'h00, 1,0,7'h05,8'h00, 0,8'h00, C_M1_ACC_R, 7'h05, 8'h00, 0, 8'h00));
        vecs.push_back(mk(1, 0,0,7'h00,8'h00, 1,1,7'h7F,8'hEE, 0,8'hAA, C_M1_ACC_R, 7'h05, 8'h00, 0, 8'h00));
        vecs.push_back(mk(1, 0,0,7'h00,8'h00, 1,1,7'h7F,8'hEE, 0,8'hAA, C_M1_ACC_R, 7'h05, 8'h00, 0, 8'h00));
        vecs.push_back(mk(1, 0,0,7'h00,8'h00, 1,0,7'h05,8'h00, 0,8'hAA, C_M1_ACC_R, 7'h05, 8'h00, 0, 8'h00));
        vecs.push_back(mk(1, 0,0,7'h00,8'h00, 1,0,7'h05,8'h00, 1,8'h3C, C_M1_OK,    7'h00, 8'h00, 1, 8'h3C));
        vecs.push_back(mk(1, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 0,8'h00, C_IDLE,     7'h00, 8'h00, 0, 8'h00));
        // reset, then both masters request continuously: m0, m1, m0, m1
        vecs.push_back(mk(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 0,8'h00, C_IDLE,     7'h00, 8'h00, 1, 8'h00));
        vecs.push_back(mk(1, 1,1,7'h21,8'h11, 1,0,7'h33,8'h00, 0,8'h00, C_M0_ACC_W, 7'h21, 8'h11, 0, 8'h00));
        vecs.push_back(mk(1, 1,1,7'h21,8'h11, 1,0,7'h33,8'h00, 1,8'h00, C_M0_OK,    7'h00, 8'h00, 1, 8'h00));
        vecs.push_back(mk(1, 1,1,7'h21,8'h11, 1,0,7'h33,8'h00, 0,8'h00, C_IDLE,     7'h00, 8'h00, 0, 8'h00));
        vecs.push_back(mk(1, 1,1,7'h21,8'h11, 1,0,7'h33,8'h00, 0,8'h00, C_M1_ACC_R, 7'h33, 8'h00, 0, 8'h00));
        vecs.push_back(mk(1, 1,1,7'h21,8'h11, 1,0,7'h33,8'h00, 1,8'h5A, C_M1_OK,    7'h00, 8'h00, 1, 8'h5A));
        vecs.push_back(mk(1, 1,1,7'h21,8'h11, 1,0,7'h33,8'h00, 0,8'h00, C_IDLE,     7'h00, 8'h00, 0, 8'h00));
        vecs.push_back(mk(1, 1,1,7'h21,8'h11, 1,0,7'h33,8'h00, 0,8'h00, C_M0_ACC_W, 7'h21, 8'h11, 0, 8'h00));
        vecs.push_back(mk(1, 1,1,7'h21,8'h11, 1,0,7'h33,8'h00, 1,8'h00, C_M0_OK,    7'h00, 8'h00, 1, 8'h00));
        vecs.push_back(mk(1, 1,1,7'h21,8'h11, 1,0,7'h33,8'h00, 0,8'h00, C_IDLE,     7'h00, 8'h00, 0, 8'h00));
        vecs.push_back(mk(1, 1,1,7'h21,8'h11, 1,0,7'h33,8'h00, 0,8'h00, C_M1_ACC_R, 7'h33, 8'h00, 0, 8'h00));
        vecs.push_back(mk(1, 1,1,7'h21,8'h11, 1,0,7'h33,8'h00, 1,8'h77, C_M1_OK,    7'h00, 8'h00, 1, 8'h77));
        vecs.push_back(mk(1, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 0,8'h00, C_IDLE,     7'h00, 8'h00, 0, 8'h00));
        // lone m1 wins although pointer prefers m0
        vecs.push_back(mk(1, 0,0,7'h00,8'h00, 1,1,7'h44,8'hC3, 0,8'h00, C_M1_ACC_W, 7'h44, 8'hC3, 0, 8'h00));
        vecs.push_back(mk(1, 0,0,7'h00,8'h00, 1,1,7'h44,8'hC3, 1,8'h00, C_M1_OK,    7'h00, 8'h00, 1, 8'h00));
        vecs.push_back(mk(1, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 0,8'h00, C_IDLE,     7'h00, 8'h00, 0, 8'h00));
        // lone m0 read
        vecs.push_back(mk(1, 1,0,7'h01,8'h00, 0,0,7'h00,8'h00, 0,8'h00, C_M0_ACC_R, 7'h01, 8'h00, 0, 8'h00));
        vecs.push_back(mk(1, 1,0,7'h01,8'h00, 0,0,7'h00,8'h00, 1,8'h99, C_M0_OK,    7'h00, 8'h00, 1, 8'h99));
        vecs.push_back(mk(1, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 0,8'h00, C_IDLE,     7'h00, 8'h00, 0, 8'h00));

        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst       = vecs[i].nrst;
            m0_req    = vecs[i].r0; m0_wr = vecs[i].w0; m0_addr = vecs[i].a0; m0_wdata = vecs[i].d0;
            m1_req    = vecs[i].r1; m1_wr = vecs[i].w1; m1_addr = vecs[i].a1; m1_wdata = vecs[i].d1;
            bus_ack   = vecs[i].ack;
            bus_rdata = vecs[i].rd;
            tick();
            chk($sformatf("vec%0d_ctl", i), {24'd0, ctl()}, {24'd0, vecs[i].exp_ctl});
            if (vecs[i].exp_ctl[1])
                chk($sformatf("vec%0d_addr", i), {25'd0, bus_addr}, {25'd0, vecs[i].exp_addr});
            if (vecs[i].exp_ctl[0])
                chk($sformatf("vec%0d_wdata", i), {24'd0, bus_wdata}, {24'd0, vecs[i].exp_wd});
            if (vecs[i].chk_rd)
                chk($sformatf("vec%0d_rdata", i), {24'd0, m_rdata}, {24'd0, vecs[i].exp_rd});
        end

        // ---- timeout: m0 read with no ack ----
        @(negedge clk);
        rst = 1'b1; bus_ack = 0; bus_rdata = 8'h55;
        m0_req = 1; m0_wr = 0; m0_addr = 7'h10; m1_req = 0;
        tick();
        chk("tmo_grant", {24'd0, ctl()}, {24'd0, C_M0_ACC_R});
        en_cnt   = 1;
        got_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (m0_done) begin
                got_done = 1'b1;
                break;
            end
            if (bus_en) en_cnt++;
        end
        chk("tmo_done_seen", {31'd0, got_done}, 32'd1);
        chk("tmo_en_cycles", en_cnt, 15);
        chk("tmo_ctl", {24'd0, ctl()}, {24'd0, C_M0_TMO});
        chk("tmo_rdata", {24'd0, m_rdata}, 32'hFF);
        @(negedge clk);
        m0_req = 0;
        tick();
        chk("tmo_idle", {24'd0, ctl()}, {24'd0, C_IDLE});

        // ---- ack on the 15th ACCESS cycle: m1 read ----
        @(negedge clk);
        m1_req = 1; m1_wr = 0; m1_addr = 7'h06;
        tick();
        chk("late_grant", {24'd0, ctl()}, {24'd0, C_M1_ACC_R});
        en_hi = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            bus_ack   = (i == 15);
            bus_rdata = (i == 15) ? 8'hE7 : 8'h00;
            tick();
            if (i < 15 && bus_en) en_hi++;
        end
        chk("late_en_cycles", en_hi, 14);
        chk("late_ctl", {24'd0, ctl()}, {24'd0, C_M1_OK});
        chk("late_rdata", {24'd0, m_rdata}, 32'hE7);
        @(negedge clk);
        m1_req = 0; bus_ack = 0;
        tick();

        // ---- reset during the 2nd ACCESS cycle ----
        // m0 transfer first so the pointer prefers m1
        @(negedge clk);
        m0_req = 1; m0_wr = 1; m0_addr = 7'h2A; m0_wdata = 8'h5E;
        tick();
        @(negedge clk);
        bus_ack = 1;
        tick();
        chk("rst_pre_done", {24'd0, ctl()}, {24'd0, C_M0_OK});
        @(negedge clk);
        m0_req = 0; bus_ack = 0;
        tick();
        @(negedge clk);
        m0_req = 1; m0_wr = 0; m0_addr = 7'h0C;
        m1_req = 1; m1_wr = 0; m1_addr = 7'h0B;
        tick();
        chk("rst_m1_grant", {24'd0, ctl()}, {24'd0, C_M1_ACC_R});
        tick();
        @(negedge clk);
        rst = 1'b0; bus_ack = 1; bus_rdata = 8'hDD;
        #1;
        chk("rst_async_ctl",   {24'd0, ctl()},     {24'd0, C_IDLE});
        chk("rst_async_addr",  {25'd0, bus_addr},  32'h0);
        chk("rst_async_wdata", {24'd0, bus_wdata}, 32'h0);
        chk("rst_async_rdata", {24'd0, m_rdata},   32'h0);
        tick();
        chk("rst_no_done", {24'd0, ctl()}, {24'd0, C_IDLE});
        @(negedge clk);
        rst = 1'b1; bus_ack = 0;
        tick();
        chk("rst_m0_first", {24'd0, ctl()}, {24'd0, C_M0_ACC_R});
        @(negedge clk);
        bus_ack = 1; bus_rdata = 8'h12;
        tick();
        chk("rst_m0_done", {24'd0, ctl()}, {24'd0, C_M0_OK});
        chk("rst_m0_rdata", {24'd0, m_rdata}, 32'h12);
        @(negedge clk);
        m0_req = 0; bus_ack = 0;
        tick();
        chk("rst_gap_idle", {24'd0, ctl()}, {24'd0, C_IDLE});
        tick();
        chk("rst_m1_next", {24'd0, ctl()}, {24'd0, C_M1_ACC_R});
        @(negedge clk);
        bus_ack = 1; bus_rdata = 8'h34;
        tick();
        chk("rst_m1_done", {24'd0, ctl()}, {24'd0, C_M1_OK});
        chk("rst_m1_rdata", {24'd0, m_rdata}, 32'h34);
        @(negedge clk);
        m1_req = 0; bus_ack = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
